// File: rtl/battle_sequencer.sv
// Top-level battle phase sequencer: drives the phase code for the attack stages,
// tracks player/enemy HP, menu selection and completed enemy rounds.
module battle_sequencer #(
  parameter int unsigned PLAYER_HP_INIT = 20,
  parameter int unsigned ENEMY_HP_INIT  = 192,
  parameter int unsigned HIT_DMG        = 4,
  parameter int unsigned MERCY_HP       = 48,
  parameter int unsigned MIN_DWELL      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  input  logic [1:0] rotate_in,
  input  logic       player_finished_in,
  input  logic       enemy_finished_in,
  input  logic       dmg_valid_in,
  input  logic [7:0] dmg_in,
  input  logic       hit_in,
  output logic [3:0] state_out,
  output logic [7:0] player_hp_out,
  output logic [7:0] enemy_hp_out,
  output logic       menu_sel_out,
  output logic [7:0] round_out
);

  localparam int unsigned DW = $clog2(MIN_DWELL + 2);
  localparam logic [7:0] P_INIT = 8'(PLAYER_HP_INIT);
  localparam logic [7:0] E_INIT = 8'(ENEMY_HP_INIT);
  localparam logic [7:0] HIT    = 8'(HIT_DMG);
  localparam logic [7:0] MERCY  = 8'(MERCY_HP);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);

  typedef enum logic [3:0] {
    TITLE  = 4'b0000,
    PLAYER = 4'b0001,
    ENEMY  = 4'b0010,
    MENU   = 4'b0011,
    WIN    = 4'b0100,
    LOSE   = 4'b0101
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    php_q, php_d;
  logic [7:0]    ehp_q, ehp_d;
  logic          sel_q, sel_d;
  logic [7:0]    round_q, round_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          start_q;
  logic [1:0]    rot_q;

  logic          start_rise;
  logic          rot_event;
  logic          honoured;
  logic [7:0]    php_hit;
  logic [7:0]    ehp_dmg;

  assign start_rise = start_in & ~start_q;
  assign rot_event  = rotate_in[1] & (rotate_in != rot_q);
  assign honoured   = (dwell_q >= DWELL_MAX);
  assign php_hit    = (php_q > HIT)    ? php_q - HIT    : '0;
  assign ehp_dmg    = (ehp_q > dmg_in) ? ehp_q - dmg_in : '0;

  always_comb begin
    state_d = state_q;
    php_d   = php_q;
    ehp_d   = ehp_q;
    sel_d   = sel_q;
    round_d = round_q;
    dwell_d = dwell_q;
    unique case (state_q)
      TITLE: begin
        if (start_rise) begin
          state_d = MENU;
          php_d   = P_INIT;
          ehp_d   = E_INIT;
          round_d = '0;
          sel_d   = 1'b0;
        end
      end
      MENU: begin
        if (rot_event) sel_d = rotate_in[0];
        // Confirm acts on the selection shown before this cycle's rotate.
        if (start_rise) begin
          if (!sel_q)              state_d = PLAYER;
          else if (ehp_q <= MERCY) state_d = WIN;
          else                     state_d = ENEMY;
        end
      end
      PLAYER: begin
        if (dmg_valid_in) ehp_d = ehp_dmg;
        if (player_finished_in && honoured)
          state_d = (ehp_d == '0) ? WIN : ENEMY;
      end
      ENEMY: begin
        if (hit_in) php_d = php_hit;
        if (php_d == '0) begin
          state_d = LOSE;
        end else if (enemy_finished_in && honoured) begin
          state_d = MENU;
          if (round_q != '1) round_d = round_q + 8'd1;
        end
      end
      WIN, LOSE: begin
        if (start_rise) state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase
    if (state_d != state_q)   dwell_d = '0;
    else if (!honoured)       dwell_d = dwell_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TITLE;
      php_q   <= P_INIT;
      ehp_q   <= E_INIT;
      sel_q   <= 1'b0;
      round_q <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      php_q   <= php_d;
      ehp_q   <= ehp_d;
      sel_q   <= sel_d;
      round_q <= round_d;
      dwell_q <= dwell_d;
    end
  end

  // Edge registers keep tracking during reset so a button held through
  // reset is not mistaken for a fresh press afterwards.
  always_ff @(posedge clk) begin
    start_q <= start_in;
    rot_q   <= rotate_in;
  end

  assign state_out     = state_q;
  assign player_hp_out = php_q;
  assign enemy_hp_out  = ehp_q;
  assign menu_sel_out  = sel_q;
  assign round_out     = round_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Scoreboard bench for battle_sequencer: directed scenarios then random stimulus,
// each cycle's expectation produced by a behavioural game model.
module tb_battle_sequencer;

  localparam int P_INIT = 20;
  localparam int E_INIT = 192;
  localparam int HIT    = 4;
  localparam int MERCY  = 48;
  localparam int DWELL  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_in = 1'b0;
  logic [1:0] rotate_in = 2'b00;
  logic       player_finished_in = 1'b0;
  logic       enemy_finished_in = 1'b0;
  logic       dmg_valid_in = 1'b0;
  logic [7:0] dmg_in = 8'd0;
  logic       hit_in = 1'b0;
  logic [3:0] state_out;
  logic [7:0] player_hp_out, enemy_hp_out, round_out;
  logic       menu_sel_out;

  battle_sequencer #(
    .PLAYER_HP_INIT(P_INIT), .ENEMY_HP_INIT(E_INIT), .HIT_DMG(HIT),
    .MERCY_HP(MERCY), .MIN_DWELL(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .rotate_in(rotate_in),
    .player_finished_in(player_finished_in), .enemy_finished_in(enemy_finished_in),
    .dmg_valid_in(dmg_valid_in), .dmg_in(dmg_in), .hit_in(hit_in),
    .state_out(state_out), .player_hp_out(player_hp_out), .enemy_hp_out(enemy_hp_out),
    .menu_sel_out(menu_sel_out), .round_out(round_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int phase; int php; int ehp; int sel; int rnd;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Game model: phase names as plain numbers, HP as signed ints clamped at zero.
  int m_phase = 0, m_php = P_INIT, m_ehp = E_INIT, m_sel = 0, m_rnd = 0;
  int m_time_in_phase = 0, m_prev_start = 0, m_prev_rot = 0;

  function automatic int max0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic model_step(input int r, input int st, input int rot, input int pf,
                            input int ef, input int dv, input int dm, input int h);
    int nxt;
    bit press, turned, ready;
    press  = (st == 1) && (m_prev_start == 0);
    turned = (rot >= 2) && (rot != m_prev_rot);
    m_prev_start = st;
    m_prev_rot   = rot;
    if (r != 0) begin
      m_phase = 0; m_php = P_INIT; m_ehp = E_INIT; m_sel = 0; m_rnd = 0;
      m_time_in_phase = 0;
      return;
    end
    ready = (m_time_in_phase >= DWELL);
    nxt = m_phase;
    if (m_phase == 0) begin
      if (press) begin nxt = 3; m_php = P_INIT; m_ehp = E_INIT; m_rnd = 0; m_sel = 0; end
    end else if (m_phase == 3) begin
      if (press) nxt = (m_sel == 0) ? 1 : ((m_ehp <= MERCY) ? 4 : 2);
      if (turned) m_sel = rot - 2;
    end else if (m_phase == 1) begin
      if (dv != 0) m_ehp = max0(m_ehp - dm);
      if (pf != 0 && ready) nxt = (m_ehp == 0) ? 4 : 2;
    end else if (m_phase == 2) begin
      if (h != 0) m_php = max0(m_php - HIT);
      if (m_php == 0) nxt = 5;
      else if (ef != 0 && ready) begin
        nxt = 3;
        if (m_rnd < 255) m_rnd++;
      end
    end else begin
      if (press) nxt = 0;
    end
    if (nxt != m_phase) m_time_in_phase = 0;
    else if (m_time_in_phase < DWELL) m_time_in_phase++;
    m_phase = nxt;
  endtask

  // Held levels used by the directed sequence.
  bit h_start = 0, h_pf = 0, h_ef = 0, h_rst = 1;
  logic [1:0] h_rot = 2'b00;

  task automatic drive(input bit r, input bit st, input logic [1:0] rot, input bit pf,
                       input bit ef, input bit dv, input logic [7:0] dm, input bit h);
    exp_t e;
    @(negedge clk);
    rst = r; start_in = st; rotate_in = rot; player_finished_in = pf;
    enemy_finished_in = ef; dmg_valid_in = dv; dmg_in = dm; hit_in = h;
    model_step(int'(r), int'(st), int'(rot), int'(pf), int'(ef), int'(dv), int'(dm), int'(h));
    e.phase = m_phase; e.php = m_php; e.ehp = m_ehp; e.sel = m_sel; e.rnd = m_rnd;
    sb.push_back(e);
  endtask

  task automatic tick(input bit dv = 0, input logic [7:0] dm = 8'd0, input bit h = 0);
    drive(h_rst, h_start, h_rot, h_pf, h_ef, dv, dm, h);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press();
    h_start = 1; tick(); h_start = 0; tick();
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("state", int'(state_out), e.phase);
        check("player_hp", int'(player_hp_out), e.php);
        check("enemy_hp", int'(enemy_hp_out), e.ehp);
        check("menu_sel", int'(menu_sel_out), e.sel);
        check("round", int'(round_out), e.rnd);
      end
    end
  end

  initial begin : stimulus
    // Start held through reset must not count as a press.
    h_rst = 1; h_start = 1; idle(3);
    h_rst = 0; idle(3);
    h_start = 0; tick();
    press(); idle(1);                       // TITLE -> MENU
    press();                                // sel 0 -> PLAYER
    h_pf = 1; idle(6);                      // dwell then ENEMY
    h_pf = 0; idle(1);
    h_ef = 1; idle(6);                      // ENEMY -> MENU, round 1
    h_ef = 0;
    press();                                // PLAYER again
    idle(4);
    tick(1, 8'd152);                        // enemy 192 -> 40
    h_pf = 1; tick(); h_pf = 0; idle(1);    // -> ENEMY
    h_ef = 1; idle(6); h_ef = 0;            // -> MENU, round 2
    h_rot = 2'b11; tick();                  // sel 1
    press();                                // 40 <= mercy -> WIN
    idle(2); press(); press(); idle(1);     // WIN -> TITLE -> MENU, HP reload
    h_rot = 2'b00; tick(); h_rot = 2'b11;
    h_start = 1; tick(); h_start = 0; tick(); // rotate with press: uses sel 0 -> PLAYER
    h_pf = 1; idle(6); h_pf = 0;            // -> ENEMY
    for (int i = 0; i < 6; i++) begin tick(0, 8'd0, 1); tick(); end  // hits to LOSE
    press(); press(); idle(1);              // LOSE -> TITLE -> MENU
    h_rot = 2'b10; tick(); h_rot = 2'b11; tick();  // sel 1, enemy 192 -> ENEMY
    press(); idle(2);
    h_ef = 1; idle(6); h_ef = 0;            // -> MENU
    h_rot = 2'b10; tick(); press();         // -> PLAYER
    idle(4);
    h_pf = 1; tick(1, 8'd200); h_pf = 0;    // saturating damage -> WIN
    idle(2); press(); press(); idle(1); press();  // into PLAYER
    h_pf = 1; idle(2);
    h_rst = 1; idle(2); h_rst = 0; h_pf = 0; idle(3);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) h_start = ~h_start;
      if ($urandom_range(0, 7) == 0) h_rot = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) h_pf = ~h_pf;
      if ($urandom_range(0, 4) == 0) h_ef = ~h_ef;
      h_rst = ($urandom_range(0, 299) == 0);
      tick(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 90)), ($urandom_range(0, 5) == 0));
    end
    h_rst = 0;
    idle(2);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
